dac_ramp_ctrl: RTL and testbench

- Slew-rate-limited setpoint controller for the R2R DAC code of the adjustable PSU.
- Accepts target output codes over a valid/ready handshake.
- Steps the DAC code toward the target by STEP every PRESCALE clocks, then holds for a settle period and pulses done.
- Sits between the front-panel/host setpoint logic and the R2R DAC, replacing a free-running counter as the DAC driver.

---
 rtl/dac_ramp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dac_ramp_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_ramp_ctrl.sv
// Slew-rate-limited setpoint controller driving the R2R DAC code of the PSU.
// Optional build macro DAC_RAMP_LIMIT_EN adds a vmax ceiling with a sticky clamped flag.
module dac_ramp_ctrl #(
  parameter int WIDTH        = 4,
  parameter int PRESCALE     = 10000,
  parameter int STEP         = 1,
  parameter int SETTLE_TICKS = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] dac_out,
  output logic             busy,
  output logic             done
`ifdef DAC_RAMP_LIMIT_EN
  ,
  input  logic [WIDTH-1:0] vmax,
  output logic             clamped
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int W1 = WIDTH + 1;
  localparam logic [PW-1:0]       PS_LAST    = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]       SETTLE_END = SW'(SETTLE_TICKS - 1);
  localparam logic signed [W1-1:0] STEP_S    = W1'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt;
  logic [WIDTH-1:0] dac_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [SW-1:0]    settle, settle_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] in_tgt;
`ifdef DAC_RAMP_LIMIT_EN
  logic             over;
  logic             clamped_nxt;
`endif

  // Distance is taken in WIDTH+1 signed bits so neither direction can wrap.
  function automatic logic within_step(input logic [WIDTH-1:0] cur,
                                       input logic [WIDTH-1:0] tgt);
    logic signed [W1-1:0] diff;
    logic signed [W1-1:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = (diff < 0) ? -diff : diff;
    return (mag <= STEP_S);
  endfunction

  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    if (within_step(cur, tgt))
      return tgt;
    else if (tgt > cur)
      return cur + WIDTH'(STEP);
    else
      return cur - WIDTH'(STEP);
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      dac_out <= '0;
      target  <= '0;
      presc   <= '0;
      settle  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef DAC_RAMP_LIMIT_EN
      clamped <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      dac_out <= dac_nxt;
      target  <= target_nxt;
      presc   <= presc_nxt;
      settle  <= settle_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
`ifdef DAC_RAMP_LIMIT_EN
      clamped <= clamped_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    dac_nxt    = dac_out;
    target_nxt = target;
    presc_nxt  = presc;
    settle_nxt = settle;
    done_nxt   = 1'b0;
    accept     = tgt_valid && (state != SETTLE);
    tick       = (presc == PS_LAST);
`ifdef DAC_RAMP_LIMIT_EN
    over        = (tgt_data > vmax);
    in_tgt      = over ? vmax : tgt_data;
    clamped_nxt = accept ? over : clamped;
`else
    in_tgt      = tgt_data;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_tgt == dac_out) begin
            done_nxt = 1'b1;
          end else begin
            target_nxt = in_tgt;
            presc_nxt  = '0;
            state_nxt  = RAMP;
          end
        end
`ifdef DAC_RAMP_LIMIT_EN
        else if (vmax < dac_out) begin
          target_nxt = vmax;
          presc_nxt  = '0;
          state_nxt  = RAMP;
        end
`endif
      end
      RAMP: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        // A retarget on a tick edge only affects the following steps.
        if (accept)
          target_nxt = in_tgt;
        if (tick) begin
          dac_nxt = step_toward(dac_out, target);
          if (within_step(dac_out, target)) begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
          end
        end
      end
      SETTLE: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (settle == SETTLE_END) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            settle_nxt = settle + SW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_comb begin
    tgt_ready = (state != SETTLE);
  end

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Scoreboard bench for dac_ramp_ctrl: stimulus queues expected DAC steps and done pulses.
module tb_dac_ramp_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         tgt_ready, busy, done;
  logic [W-1:0] dac_out;
  logic         t4_valid = 1'b0;
  logic [W-1:0] t4_data = '0;
  logic         t4_ready, busy4, done4;
  logic [W-1:0] dac4;
`ifdef DAC_RAMP_LIMIT_EN
  logic [W-1:0] vmax = 4'd15;
  logic [W-1:0] vmax4 = 4'd15;
  logic         clamped, clamped4;
`endif

  dac_ramp_ctrl #(.WIDTH(W), .PRESCALE(4), .STEP(1), .SETTLE_TICKS(2)) dut (
    .clk(clk), .n_rst(n_rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .dac_out(dac_out), .busy(busy), .done(done)
`ifdef DAC_RAMP_LIMIT_EN
    , .vmax(vmax), .clamped(clamped)
`endif
  );

  dac_ramp_ctrl #(.WIDTH(W), .PRESCALE(4), .STEP(4), .SETTLE_TICKS(2)) dut4 (
    .clk(clk), .n_rst(n_rst), .tgt_valid(t4_valid), .tgt_data(t4_data),
    .tgt_ready(t4_ready), .dac_out(dac4), .busy(busy4), .done(done4)
`ifdef DAC_RAMP_LIMIT_EN
    , .vmax(vmax4), .clamped(clamped4)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit is_done;
    int val;
    int edge_no;
  } ev_t;

  ev_t q1[$];
  ev_t q4[$];
  int  checks = 0;
  int  errors = 0;
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last4 = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int which, input bit d, input int v, input int e);
    ev_t ev;
    ev.is_done = d;
    ev.val     = v;
    ev.edge_no = e;
    if (which == 1) q1.push_back(ev);
    else            q4.push_back(ev);
  endtask

  // Expected trace for an uninterrupted ramp: one step per 4 edges, done 2 ticks after arrival.
  task automatic push_ramp(input int which, input int from, input int to, input int step, input int acc);
    int cur;
    int e;
    cur = from;
    e   = acc;
    while (cur != to) begin
      e += 4;
      if (to > cur) cur = (to - cur <= step) ? to : cur + step;
      else          cur = (cur - to <= step) ? to : cur - step;
      push(which, 1'b0, cur, e);
    end
    push(which, 1'b1, 0, e + 8);
  endtask

  task automatic observe(input int which, input bit is_done, input int val);
    ev_t ev;
    bit  have;
    have = 1'b0;
    if (which == 1 && q1.size() != 0) begin ev = q1.pop_front(); have = 1'b1; end
    if (which == 4 && q4.size() != 0) begin ev = q4.pop_front(); have = 1'b1; end
    checks++;
    if (!have || ev.is_done != is_done) begin
      errors++;
      $display("FAIL mon%0d_event: got %s=%0d at edge %0d, expected %s", which,
               is_done ? "done" : "dac", val, edge_cnt, have ? "other event kind" : "no event");
    end else begin
      chk(is_done ? "done_edge" : "dac_edge", edge_cnt, ev.edge_no);
      chk(is_done ? "done_val" : "dac_val", val, ev.val);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (dac_out !== last1) observe(1, 1'b0, int'(dac_out));
      if (done)              observe(1, 1'b1, 0);
      if (dac4 !== last4)    observe(4, 1'b0, int'(dac4));
      if (done4)             observe(4, 1'b1, 0);
    end
    last1 = dac_out;
    last4 = dac4;
  end

  task automatic at_edge(input int n);
    @(negedge clk);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic send(input int d, output int acc);
    tgt_data  = W'(d);
    tgt_valid = 1'b1;
    acc       = edge_cnt + 1;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
  endtask

  task automatic send4(input int d, output int acc);
    t4_data  = W'(d);
    t4_valid = 1'b1;
    acc      = edge_cnt + 1;
    @(posedge clk);
    #1 t4_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", (which == 1) ? q1.size() : q4.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a;
    int s;
    repeat (2) @(negedge clk);
    chk("rst_dac", dac_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_dac4", dac4, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Basic ramp 0 -> 5 with handshake and busy timing.
    send(5, a);
    for (int k = 1; k <= 5; k++) push(1, 1'b0, k, a + 4 * k);
    push(1, 1'b1, 0, a + 28);
    at_edge(a);      chk("t1_busy_start", busy, 1);
    at_edge(a + 20); chk("t1_ready_settle", tgt_ready, 0); chk("t1_busy_settle", busy, 1);
    at_edge(a + 27); chk("t1_ready_late", tgt_ready, 0);
    at_edge(a + 28); chk("t1_ready_end", tgt_ready, 1); chk("t1_busy_end", busy, 0);
    drain(1);

    // Same target while idle: immediate done, no ramp.
    send(5, a);
    push(1, 1'b1, 0, a);
    at_edge(a); chk("t2_busy", busy, 0); chk("t2_dac", dac_out, 5);
    drain(1);

    // Ramp down to 0, then retarget 10 -> 0 mid-ramp.
    send(0, a);
    for (int k = 1; k <= 5; k++) push(1, 1'b0, 5 - k, a + 4 * k);
    push(1, 1'b1, 0, a + 28);
    drain(1);
    send(10, a);
    push(1, 1'b0, 1, a + 4);
    push(1, 1'b0, 2, a + 8);
    at_edge(a + 8);
    send(0, s);
    push(1, 1'b0, 1, a + 12);
    push(1, 1'b0, 0, a + 16);
    push(1, 1'b1, 0, a + 24);
    drain(1);

    // Retarget accepted on the same edge as a tick: that step still heads for 8.
    send(8, a);
    push(1, 1'b0, 1, a + 4);
    at_edge(a + 7);
    send(0, s);
    push(1, 1'b0, 2, a + 8);
    push(1, 1'b0, 1, a + 12);
    push(1, 1'b0, 0, a + 16);
    push(1, 1'b1, 0, a + 24);
    drain(1);

    // Async reset mid-ramp discards the target and suppresses done.
    send(5, a);
    for (int k = 1; k <= 3; k++) push(1, 1'b0, k, a + 4 * k);
    at_edge(a + 13);
    #2 n_rst = 1'b0;
    #1 chk("mid_rst_dac", dac_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pending", q1.size(), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_dac", dac_out, 0);
    send(1, a);
    push(1, 1'b0, 1, a + 4);
    push(1, 1'b1, 0, a + 12);
    drain(1);

    // Full-scale boundaries.
    send(15, a);
    push_ramp(1, 1, 15, 1, a);
    drain(1);
    chk("top_dac", dac_out, 15);
    send(0, a);
    push_ramp(1, 15, 0, 1, a);
    drain(1);
    chk("bottom_dac", dac_out, 0);

    // STEP=4 instance: last step lands exactly on 15.
    send4(15, a);
    push(4, 1'b0, 4, a + 4);
    push(4, 1'b0, 8, a + 8);
    push(4, 1'b0, 12, a + 12);
    push(4, 1'b0, 15, a + 16);
    push(4, 1'b1, 0, a + 24);
    drain(4);

`ifdef DAC_RAMP_LIMIT_EN
    vmax = 4'd6;
    @(negedge clk);
    send(12, a);
    for (int k = 1; k <= 6; k++) push(1, 1'b0, k, a + 4 * k);
    push(1, 1'b1, 0, a + 32);
    at_edge(a); chk("lim_clamped_set", clamped, 1);
    drain(1);
    vmax = 4'd3;
    s = edge_cnt + 1;
    push(1, 1'b0, 5, s + 4);
    push(1, 1'b0, 4, s + 8);
    push(1, 1'b0, 3, s + 12);
    push(1, 1'b1, 0, s + 20);
    drain(1);
    chk("lim_clamped_hold", clamped, 1);
    send(2, a);
    push(1, 1'b0, 2, a + 4);
    push(1, 1'b1, 0, a + 12);
    at_edge(a); chk("lim_clamped_clr", clamped, 0);
    drain(1);
    vmax = 4'd15;
`endif

    chk("final_q1", q1.size(), 0);
    chk("final_q4", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
